// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Imported by the interface, the arbiter and the top level.
package mult_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int WIDTH_DEFAULT = 32;
   localparam int NREQ_MIN      = 2;
   localparam int NREQ_MAX      = 4;
endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side operand/result bus of mult_arbiter.
// The master drives operands and accepts results; the slave is the arbiter.
interface mult_arbiter_if #(
   parameter int NREQ  = 2,
   parameter int WIDTH = mult_pkg::WIDTH_DEFAULT
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_m;
   logic [NREQ*WIDTH-1:0] req_q;
   logic [NREQ-1:0]       resp_valid;
   logic [NREQ-1:0]       resp_ready;
   logic [2*WIDTH-1:0]    resp_prod;
   logic                  resp_err;

   modport master (
      output req_valid, req_m, req_q, resp_ready,
      input  req_ready, resp_valid, resp_prod, resp_err
   );

   modport slave (
      input  req_valid, req_m, req_q, resp_ready,
      output req_ready, resp_valid, resp_prod, resp_err
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and the
// first asserted request wins. Grants nothing while en is low.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   input  logic                    en,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] gnt_idx
);
   localparam int IW = $clog2(NREQ);

   logic found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (en && !found && req[(int'(ptr) + k) % NREQ]) begin
            gnt[(int'(ptr) + k) % NREQ] = 1'b1;
            gnt_idx = IW'((int'(ptr) + k) % NREQ);
            found   = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mult_arbiter.sv
// Shares one iterative multiplier between NREQ requesters: accepts operands
// round-robin, starts the multiplier, and returns the product or a timeout error.
module mult_arbiter
   import mult_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   mult_arbiter_if.slave      bus,
   output logic               mul_start,
   output logic [WIDTH-1:0]   mul_m,
   output logic [WIDTH-1:0]   mul_q,
   input  logic [2*WIDTH-1:0] mul_prod,
   input  logic               mul_valid,
   output logic               busy
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [IW-1:0]      r_ptr;
   logic [IW-1:0]      r_gidx;
   logic [WIDTH-1:0]   r_m;
   logic [WIDTH-1:0]   r_q;
   logic [2*WIDTH-1:0] r_prod;
   logic               r_err;
   logic               r_start;
   logic [CW-1:0]      r_cnt;

   logic [NREQ-1:0]    w_gnt;
   logic [IW-1:0]      w_gnt_idx;
   logic               w_arb_en;
   logic               w_timeout;
   logic [WIDTH-1:0]   w_m_arr [NREQ];
   logic [WIDTH-1:0]   w_q_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign w_m_arr[gi] = bus.req_m[gi*WIDTH +: WIDTH];
         assign w_q_arr[gi] = bus.req_q[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Gating with reset keeps req_ready at zero while reset is held.
   assign w_arb_en = (r_state == ST_IDLE) && reset;

   rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
      .req     (bus.req_valid),
      .ptr     (r_ptr),
      .en      (w_arb_en),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   // The counter reaches TIMEOUT on the edge closing the TIMEOUT-th WAIT cycle.
   assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

   always_comb begin
      w_state_next   = r_state;
      busy           = (r_state != ST_IDLE);
      bus.resp_valid = '0;
      case (r_state)
         ST_IDLE:  if (|w_gnt) w_state_next = ST_ISSUE;
         ST_ISSUE: w_state_next = ST_WAIT;
         ST_WAIT:  if (mul_valid || w_timeout) w_state_next = ST_RESP;
         ST_RESP: begin
            bus.resp_valid[r_gidx] = 1'b1;
            if (bus.resp_ready[r_gidx]) w_state_next = ST_IDLE;
         end
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_ptr   <= IW'(NREQ - 1);
         r_gidx  <= '0;
         r_m     <= '0;
         r_q     <= '0;
         r_prod  <= '0;
         r_err   <= 1'b0;
         r_start <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         // Registered so the start pulse cannot glitch on state decoding.
         r_start <= (w_state_next == ST_ISSUE);
         case (r_state)
            ST_IDLE: begin
               if (|w_gnt) begin
                  r_gidx <= w_gnt_idx;
                  r_m    <= w_m_arr[w_gnt_idx];
                  r_q    <= w_q_arr[w_gnt_idx];
               end
            end
            ST_ISSUE: r_cnt <= '0;
            ST_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (mul_valid) begin
                  r_prod <= mul_prod;
                  r_err  <= 1'b0;
               end else if (w_timeout) begin
                  r_prod <= '0;
                  r_err  <= 1'b1;
               end
            end
            ST_RESP: if (bus.resp_ready[r_gidx]) r_ptr <= r_gidx;
            default: ;
         endcase
      end
   end

   assign bus.req_ready = w_gnt;
   assign bus.resp_prod = r_prod;
   assign bus.resp_err  = r_err;
   assign mul_start     = r_start;
   assign mul_m         = r_m;
   assign mul_q         = r_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized bench for mult_arbiter with an in-bench multiplier of programmable
// latency and a transaction-level model of grant order, result and timing.
module tb_mult_arbiter;
   localparam int NREQ    = 3;
   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic               mul_start;
   logic [WIDTH-1:0]   mul_m;
   logic [WIDTH-1:0]   mul_q;
   logic [2*WIDTH-1:0] mul_prod;
   logic               mul_valid;
   logic               busy;

   int n_checks = 0;
   int n_errors = 0;
   int ref_ptr;
   logic [WIDTH-1:0] op_m [NREQ];
   logic [WIDTH-1:0] op_q [NREQ];

   always #5 clk = ~clk;

   mult_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .mul_start (mul_start),
      .mul_m     (mul_m),
      .mul_q     (mul_q),
      .mul_prod  (mul_prod),
      .mul_valid (mul_valid),
      .busy      (busy)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int ref_grant(input logic [NREQ-1:0] mask);
      for (int k = 1; k <= NREQ; k++)
         if (mask[(ref_ptr + k) % NREQ]) return (ref_ptr + k) % NREQ;
      return -1;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_start"}, mul_start, 0);
      check_eq({tag, "_mul_m"}, mul_m, 0);
      check_eq({tag, "_mul_q"}, mul_q, 0);
      check_eq({tag, "_resp_valid"}, bus.resp_valid, 0);
      check_eq({tag, "_req_ready"}, bus.req_ready, 0);
      check_eq({tag, "_resp_prod"}, bus.resp_prod, 0);
      check_eq({tag, "_resp_err"}, bus.resp_err, 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      #1 check_reset_outputs("reset");
      @(negedge clk);
      reset   = 1'b1;
      ref_ptr = NREQ - 1;
   endtask

   task automatic scramble();
      bus.req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
         bus.req_m[i*WIDTH +: WIDTH] = $urandom;
         bus.req_q[i*WIDTH +: WIDTH] = $urandom;
      end
   endtask

   // Runs one operation from the IDLE negedge to the IDLE negedge after the
   // response handshake. lat = multiplier latency after start, 0 = never answers.
   task automatic do_op(input logic [NREQ-1:0] mask, input int lat, input int bp, input bit early);
      int g;
      int resp_cyc;
      logic [NREQ-1:0]    exp_oh;
      logic [WIDTH-1:0]   em;
      logic [WIDTH-1:0]   eq;
      logic [2*WIDTH-1:0] true_prod;
      logic [2*WIDTH-1:0] exp_prod;
      logic               exp_err;

      g = ref_grant(mask);
      exp_oh = '0;
      exp_oh[g] = 1'b1;
      bus.req_valid  = mask;
      bus.resp_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_m[i*WIDTH +: WIDTH] = op_m[i];
         bus.req_q[i*WIDTH +: WIDTH] = op_q[i];
      end
      em = op_m[g];
      eq = op_q[g];
      true_prod = {{WIDTH{1'b0}}, em} * {{WIDTH{1'b0}}, eq};
      if (lat != 0 && lat <= TIMEOUT) begin
         exp_prod = true_prod;
         exp_err  = 1'b0;
         resp_cyc = lat + 1;
      end else begin
         exp_prod = '0;
         exp_err  = 1'b1;
         resp_cyc = TIMEOUT + 1;
      end

      #1;
      check_eq("accept_ready", bus.req_ready, exp_oh);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_start", mul_start, 0);
      @(posedge clk);
      @(negedge clk);

      // Cycle c after the accept-following cycle; c == 0 is the start cycle.
      for (int c = 0; c < resp_cyc; c++) begin
         if (c == 0) begin
            check_eq("start_pulse", mul_start, 1);
            scramble();
         end else begin
            check_eq("start_low", mul_start, 0);
         end
         check_eq("op_m", mul_m, em);
         check_eq("op_q", mul_q, eq);
         check_eq("wait_busy", busy, 1);
         check_eq("wait_resp_valid", bus.resp_valid, 0);
         check_eq("wait_req_ready", bus.req_ready, 0);
         if (c == 0) begin
            mul_valid = 1'($urandom);
            mul_prod  = {$urandom, $urandom};
         end else begin
            mul_valid = (c == lat);
            mul_prod  = (c == lat) ? true_prod : {$urandom, $urandom};
         end
         if (early && c == resp_cyc - 1) bus.resp_ready[g] = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end

      // Response phase; stray multiplier pulses here must be ignored.
      for (int b = 0; b <= (early ? 0 : bp); b++) begin
         check_eq("resp_valid", bus.resp_valid, exp_oh);
         check_eq("resp_prod", bus.resp_prod, exp_prod);
         check_eq("resp_err", bus.resp_err, exp_err);
         check_eq("resp_busy", busy, 1);
         check_eq("resp_op_m", mul_m, em);
         mul_valid = 1'b1;
         mul_prod  = {$urandom, $urandom};
         if (early) begin
            bus.req_valid = '1;
            #1 check_eq("resp_req_ready", bus.req_ready, 0);
         end else if (b < bp) begin
            bus.req_valid  = '1;
            bus.resp_ready = NREQ'($urandom);
            bus.resp_ready[g] = 1'b0;
            #1 check_eq("bp_req_ready", bus.req_ready, 0);
         end else begin
            bus.resp_ready[g] = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
      end

      mul_valid      = 1'b0;
      bus.resp_ready = '0;
      bus.req_valid  = '0;
      check_eq("done_resp_valid", bus.resp_valid, 0);
      check_eq("done_busy", busy, 0);
      ref_ptr = g;
      $display("op g=%0d m=0x%0h q=0x%0h lat=%0d bp=%0d early=%0b prod=0x%0h err=%0b",
               g, em, eq, lat, bp, early, exp_prod, exp_err);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b0;
      bus.req_valid  = '0;
      bus.req_m      = '0;
      bus.req_q      = '0;
      bus.resp_ready = '0;
      mul_valid      = 1'b0;
      mul_prod       = '0;
      ref_ptr        = NREQ - 1;
      for (int i = 0; i < NREQ; i++) begin
         op_m[i] = '0;
         op_q[i] = '0;
      end
      repeat (2) @(negedge clk);
      #1 check_reset_outputs("por");
      @(negedge clk);
      reset = 1'b1;

      // Single request.
      op_m[0] = 234; op_q[0] = 1243;
      do_op(3'b001, 3, 0, 0);

      // Simultaneous requests straight after reset, then req0 again.
      apply_reset();
      op_m[0] = 3; op_q[0] = 5;
      op_m[1] = 7; op_q[1] = 9;
      do_op(3'b011, 2, 0, 0);
      do_op(3'b011, 4, 0, 1);
      do_op(3'b011, 1, 0, 0);

      // Full-width operands.
      op_m[0] = 32'hFFFF_FFFF; op_q[0] = 32'hFFFF_FFFF;
      do_op(3'b001, 5, 0, 0);

      // Ten cycles of response backpressure with req0 competing.
      op_m[1] = 123456; op_q[1] = 789;
      do_op(3'b011, 6, 10, 0);

      // Timeout, tie with the timeout, and a late pulse after the timeout.
      op_m[2] = 11; op_q[2] = 13;
      do_op(3'b100, 0, 1, 0);
      op_m[0] = 17; op_q[0] = 19;
      do_op(3'b001, TIMEOUT, 0, 0);
      do_op(3'b001, TIMEOUT + 1, 0, 1);

      // Reset in the middle of WAIT.
      op_m[1] = 40; op_q[1] = 50;
      bus.req_valid = 3'b010;
      bus.req_m[1*WIDTH +: WIDTH] = op_m[1];
      bus.req_q[1*WIDTH +: WIDTH] = op_q[1];
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check_reset_outputs("midop");
      @(negedge clk);
      reset = 1'b1;
      ref_ptr = NREQ - 1;
      bus.req_valid = '0;
      #1 check_eq("post_reset_busy", busy, 0);
      @(negedge clk);
      op_m[0] = 2; op_q[0] = 2;
      do_op(3'b011, 3, 0, 0);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         logic [NREQ-1:0] mask;
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            case ($urandom_range(0, 5))
               0:       begin op_m[i] = '1; op_q[i] = '1; end
               1:       begin op_m[i] = '0; op_q[i] = $urandom; end
               default: begin op_m[i] = $urandom; op_q[i] = $urandom; end
            endcase
         end
         do_op(mask, $urandom_range(0, TIMEOUT + 2), $urandom_range(0, 3), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
